mem_arbiter_rr: RTL

//  N-port round-robin arbiter that multiplexes N memory-bus masters (CPU, MCGA, DMA, ...) onto
//  one SDRAM controller port. One transaction outstanding at a time; fair rotating priority;

---
 rtl/mem_arbiter_rr_if.sv | 66 ++++++
 rtl/mem_arbiter_rr.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr_if
// Bundles the N bus-master ports and the single SDRAM-controller port of the
// round-robin memory arbiter.
//
// Per-port vectors are flat. Port i occupies slice [i*W +: W]:
//   m_addr      N_PORTS*ADDR_W  word address of each master
//   m_data_out  N_PORTS*DATA_W  write data from each master
//   m_data_in   N_PORTS*DATA_W  registered read data back to each master
//   m_access    N_PORTS         request, held high until the matching m_ack
//   m_ack       N_PORTS         one-cycle registered completion, one-hot or zero
//   m_wr_en     N_PORTS         write enable
//   m_bytesel   N_PORTS*BSEL_W  byte selects
// Controller side:
//   sdram_m_addr      [ADDR_W:1]  muxed word address
//   sdram_m_data_out  DATA_W      muxed write data
//   sdram_m_data_in   DATA_W      read data from the controller
//   sdram_m_access    1           request to the controller
//   sdram_m_ack       1           one-cycle completion from the controller
//   sdram_m_wr_en     1           muxed write enable
//   sdram_m_bytesel   BSEL_W      muxed byte selects
//
// Handshake: a master raises m_access[i] with stable addr/data/wr_en/bytesel
// and holds it until it sees m_ack[i] (one cycle). The controller sees
// sdram_m_access while a grant is held and the granted master still
// requests; it completes the transfer with a one-cycle sdram_m_ack.
// Dropping m_access before completion abandons the transfer.
//
// Modports: slave = arbiter view, master = environment (masters + controller).
// -----------------------------------------------------------------------------
interface mem_arbiter_rr_if #(
   parameter int N_PORTS = 3,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 16,
   parameter int BSEL_W  = 2
);
   logic [N_PORTS*ADDR_W-1:0] m_addr;
   logic [N_PORTS*DATA_W-1:0] m_data_out;
   logic [N_PORTS*DATA_W-1:0] m_data_in;
   logic [N_PORTS-1:0]        m_access;
   logic [N_PORTS-1:0]        m_ack;
   logic [N_PORTS-1:0]        m_wr_en;
   logic [N_PORTS*BSEL_W-1:0] m_bytesel;

   logic [ADDR_W:1]           sdram_m_addr;
   logic [DATA_W-1:0]         sdram_m_data_in;
   logic [DATA_W-1:0]         sdram_m_data_out;
   logic                      sdram_m_access;
   logic                      sdram_m_ack;
   logic                      sdram_m_wr_en;
   logic [BSEL_W-1:0]         sdram_m_bytesel;

   modport slave (
      input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
      input  sdram_m_data_in, sdram_m_ack,
      output m_data_in, m_ack,
      output sdram_m_addr, sdram_m_data_out, sdram_m_access, sdram_m_wr_en, sdram_m_bytesel
   );

   modport master (
      output m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
      output sdram_m_data_in, sdram_m_ack,
      input  m_data_in, m_ack,
      input  sdram_m_addr, sdram_m_data_out, sdram_m_access, sdram_m_wr_en, sdram_m_bytesel
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
// N-port round-robin arbiter putting N memory-bus masters onto one SDRAM
// controller port. One transaction outstanding at a time; the search for the
// next grant starts just after the last completed port. Ack and read data
// back to the masters are registered (one cycle after sdram_m_ack).
//
// Ports:
//   clk           system clock
//   reset_n       synchronous active-low reset
//   bus           mem_arbiter_rr_if.slave (master ports + controller port)
//   grant_idx     port currently (or last) granted
//   grant_active  a grant is held (FSM in SERVE)
//   timeout_err   one-cycle pulse on watchdog abort (tied 0 without the macro)
//   state_dbg     FSM state: 0 = IDLE, 1 = SERVE
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined: a watchdog counts SERVE cycles and aborts the grant after
//   TIMEOUT cycles without sdram_m_ack; the offender moves to the back of the
//   rotation. Undefined: SERVE waits indefinitely.
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
   parameter int   N_PORTS = 3,
   parameter int   ADDR_W  = 19,
   parameter int   DATA_W  = 16,
   parameter int   BSEL_W  = 2,
   parameter int   TIMEOUT = 255,
   localparam int  IDX_W   = $clog2(N_PORTS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mem_arbiter_rr_if.slave       bus,
   output logic [IDX_W-1:0]      grant_idx,
   output logic                  grant_active,
   output logic                  timeout_err,
   output logic                  state_dbg
);

   if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mem_arbiter_rr: N_PORTS must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   grant_idx_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [N_PORTS-1:0] ack_nxt;
   logic               capture;
   logic [IDX_W:0]     pick;

   // Returns {hit, index} of the first requester after 'from', wrapping.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [IDX_W-1:0]   from);
      logic [IDX_W:0] res;
      int             cand;
      res = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand = (int'(from) + k) % N_PORTS;
         if (!res[IDX_W] && req[cand]) res = {1'b1, IDX_W'(cand)};
      end
      return res;
   endfunction

   assign pick         = rr_pick(bus.m_access, last);
   assign grant_active = (state == SERVE);
   assign state_dbg    = state;

   // Address/data/control always follow grant_idx, even while idle; only the
   // request itself is qualified by the grant.
   assign bus.sdram_m_addr     = bus.m_addr[grant_idx*ADDR_W +: ADDR_W];
   assign bus.sdram_m_data_out = bus.m_data_out[grant_idx*DATA_W +: DATA_W];
   assign bus.sdram_m_wr_en    = bus.m_wr_en[grant_idx];
   assign bus.sdram_m_bytesel  = bus.m_bytesel[grant_idx*BSEL_W +: BSEL_W];
   assign bus.sdram_m_access   = grant_active & bus.m_access[grant_idx];

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wdog, wdog_nxt;
   logic            tmo_nxt;
`endif

   always_comb begin
      state_nxt     = state;
      grant_idx_nxt = grant_idx;
      last_nxt      = last;
      ack_nxt       = '0;
      capture       = 1'b0;
`ifdef ARB_TIMEOUT_EN
      wdog_nxt      = wdog;
      tmo_nxt       = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pick[IDX_W]) begin
               state_nxt     = SERVE;
               grant_idx_nxt = pick[IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
               wdog_nxt      = '0;
`endif
            end
         end
         SERVE: begin
`ifdef ARB_TIMEOUT_EN
            wdog_nxt = wdog + 1'b1;
`endif
            if (bus.sdram_m_ack) begin
               state_nxt          = IDLE;
               last_nxt           = grant_idx;
               ack_nxt[grant_idx] = 1'b1;
               capture            = 1'b1;
            end else if (!bus.m_access[grant_idx]) begin
               // Abandoned transfer: rotation point stays where it was.
               state_nxt = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wdog == WD_W'(TIMEOUT - 1)) begin
               // Offender goes to the back of the rotation.
               state_nxt = IDLE;
               last_nxt  = grant_idx;
               tmo_nxt   = 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         grant_idx     <= '0;
         last          <= IDX_W'(N_PORTS - 1);
         bus.m_ack     <= '0;
         bus.m_data_in <= '0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_idx_nxt;
         last      <= last_nxt;
         bus.m_ack <= ack_nxt;
         if (capture) bus.m_data_in[grant_idx*DATA_W +: DATA_W] <= bus.sdram_m_data_in;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wdog        <= '0;
         timeout_err <= 1'b0;
      end else begin
         wdog        <= wdog_nxt;
         timeout_err <= tmo_nxt;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule
